fnd_scan_ctrl: RTL and testbench

//  Parametrised multiplexed 7-segment (FND) scan controller for the stopwatch display path.
//  - Time-multiplexes DIGITS hex nibbles onto one shared segment bus.
//  - Drives an active-low one-cold common bus, with a built-in scan prescaler.
//  - Adds hex decode, decimal points, per-digit blanking and leading-zero suppression.
//  - Sits between the stopwatch BCD/time datapath and the board FND pins.

---
 rtl/fnd_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_fnd_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: prescaler, digit sequencer, hex decode, blanking.
// Optional FND_GHOST_BLANK_EN inserts GUARD_CYCLES dark cycles at the start of every slot.
module fnd_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 16,
  parameter int GUARD_CYCLES = 2,
  localparam int IW          = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     com,
  output logic [7:0]            seg,
  output logic [IW-1:0]         digit_idx,
  output logic                  scan_tick
);

  localparam int PW = $clog2(SCAN_DIV);
`ifdef FND_GHOST_BLANK_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] com_q, com_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] lz_s;
  logic [3:0]        nib_s;
  logic              last_s;
  logic              guard_s;

  // Active-low segments a..g for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;
      4'h1: r = 7'h79;
      4'h2: r = 7'h24;
      4'h3: r = 7'h30;
      4'h4: r = 7'h19;
      4'h5: r = 7'h12;
      4'h6: r = 7'h02;
      4'h7: r = 7'h78;
      4'h8: r = 7'h00;
      4'h9: r = 7'h10;
      4'hA: r = 7'h08;
      4'hB: r = 7'h03;
      4'hC: r = 7'h46;
      4'hD: r = 7'h21;
      4'hE: r = 7'h06;
      4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign last_s    = (presc_q == PW'(SCAN_DIV - 1));
  assign guard_s   = GUARD_ON && (presc_q < PW'(GUARD_CYCLES));
  assign nib_s     = value[4*idx_q +: 4];
  assign scan_tick = reset_n & enable & last_s;
  assign com       = com_q;
  assign seg       = seg_q;
  assign digit_idx = idx_q;

  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      if (last_s) begin
        presc_d = '0;
        idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = presc_q;
      idx_d   = idx_q;
    end
  end

  // lz_s[i]: every nibble from i up to the top digit is zero; digit 0 never qualifies.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_s       = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (value[4*i +: 4] == 4'h0);
      lz_s[i]    = upper_zero;
    end
  end

  always_comb begin
    com_d = '1;
    seg_d = 8'hFF;
    if (!enable || guard_s) begin
      com_d = '1;
      seg_d = 8'hFF;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        com_d[i] = (idx_q != IW'(i));
      end
      // Blanked digits keep their common low so the slot timing stays uniform.
      if (blank_mask[idx_q]) begin
        seg_d = 8'hFF;
      end else if (lz_suppress && lz_s[idx_q]) begin
        seg_d = {~dp[idx_q], 7'h7F};
      end else begin
        seg_d = {~dp[idx_q], hex7(nib_s)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      com_q   <= '1;
      seg_q   <= 8'hFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      com_q   <= com_d;
      seg_q   <= seg_d;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl (DIGITS=4, SCAN_DIV=4, GUARD_CYCLES=2).
module tb_fnd_scan_ctrl;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int G  = 2;
`ifdef FND_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n, enable, lz_suppress;
  logic [15:0]  value;
  logic [3:0]   dp, blank_mask, com;
  logic [7:0]   seg;
  logic [1:0]   digit_idx;
  logic         scan_tick;

  always #5 clk = ~clk;

  fnd_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .GUARD_CYCLES(G)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .value(value), .dp(dp),
    .blank_mask(blank_mask), .lz_suppress(lz_suppress), .com(com), .seg(seg),
    .digit_idx(digit_idx), .scan_tick(scan_tick)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] dec [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: cnt = enabled cycles since reset; slot = cnt/SD, digit = slot%D.
  int         cnt = 0;
  logic [3:0] exp_com = 4'hF;
  logic [7:0] exp_seg = 8'hFF;
  bit         chk_en = 1'b0;

  function automatic logic [11:0] model_out(int c);
    int  d;
    bit  upper_zero;
    logic [7:0] s;
    d = (c / SD) % D;
    if (GHOST && (c % SD) < G) return {4'hF, 8'hFF};
    upper_zero = 1'b1;
    for (int j = d; j < D; j++) if (value[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    if (blank_mask[d])                         s = 8'hFF;
    else if (lz_suppress && d > 0 && upper_zero) s = {~dp[d], 7'h7F};
    else                                       s = {~dp[d], dec[value[4*d +: 4]][6:0]};
    return {~(4'b0001 << d), s};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      cnt <= 0; exp_com <= 4'hF; exp_seg <= 8'hFF;
    end else if (enable) begin
      {exp_com, exp_seg} <= model_out(cnt);
      cnt <= cnt + 1;
    end else begin
      exp_com <= 4'hF; exp_seg <= 8'hFF;
    end
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("com", 32'(com), 32'(exp_com));
      check("seg", 32'(seg), 32'(exp_seg));
      check("digit_idx", 32'(digit_idx), 32'((cnt / SD) % D));
      check("scan_tick", 32'(scan_tick), 32'(reset_n && enable && (cnt % SD == SD - 1)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_com(input logic [3:0] t, input string n);
    int k = 0;
    @(negedge clk);
    while (com !== t && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(n, 32'(com), 32'(t));
  endtask

  task automatic wait_slot(input int dig, input int ph, input string n);
    int k = 0;
    @(negedge clk);
    while (!((cnt % SD) == ph && ((cnt / SD) % D) == dig) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(n, 32'(k < 40), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; value = 16'h1234;
    dp = 4'h0; blank_mask = 4'h0; lz_suppress = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_com", 32'(com), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h000000FF);
    check("rst_idx", 32'(digit_idx), 32'd0);
    check("rst_tick", 32'(scan_tick), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    wait_com(4'b1110, "t2_wait_d0"); check("t2_seg_d0", 32'(seg), 32'h99);
    wait_com(4'b1101, "t2_wait_d1"); check("t2_seg_d1", 32'(seg), 32'hB0);
    wait_com(4'b0111, "t2_wait_d3"); check("t2_seg_d3", 32'(seg), 32'hF9);
    step(20);

    dp = 4'b0001;
    for (int v = 0; v < 16; v++) begin
      value = {12'h123, 4'(v)};
      @(posedge clk);
      wait_com(4'b1110, "t3_wait");
      if (v == 0)  check("t3_seg_0", 32'(seg), 32'h40);
      if (v == 15) check("t3_seg_F", 32'(seg), 32'h0E);
      step(12);
    end

    dp = 4'h0; value = 16'h0012; lz_suppress = 1'b1;
    @(posedge clk);
    wait_com(4'b0111, "t4_wait_d3"); check("t4_lz_d3", 32'(seg), 32'hFF);
    wait_com(4'b1011, "t4_wait_d2"); check("t4_lz_d2", 32'(seg), 32'hFF);
    wait_com(4'b1101, "t4_wait_d1"); check("t4_d1", 32'(seg), 32'hF9);
    wait_com(4'b1110, "t4_wait_d0"); check("t4_d0", 32'(seg), 32'hA4);
    step(1); value = 16'h0000;
    @(posedge clk);
    wait_com(4'b1110, "t4_wait_z0"); check("t4_zero_d0", 32'(seg), 32'hC0);
    wait_com(4'b1101, "t4_wait_z1"); check("t4_zero_d1", 32'(seg), 32'hFF);
    step(1); dp = 4'b1000;
    @(posedge clk);
    wait_com(4'b0111, "t4_wait_dp3"); check("t4_lz_dp3", 32'(seg), 32'h7F);
    step(1); dp = 4'h0; blank_mask = 4'b0001;
    @(posedge clk);
    wait_com(4'b1110, "t4_wait_bm"); check("t4_mask_d0", 32'(seg), 32'hFF);
    step(16);

    blank_mask = 4'h0; lz_suppress = 1'b0; value = 16'h1234;
    wait_slot(1, 1, "t5_sync_en");
    @(posedge clk); #1 enable = 1'b0;
    step(3);
    @(negedge clk);
    check("t5_off_com", 32'(com), 32'h0000000F);
    check("t5_off_idx", 32'(digit_idx), 32'd1);
    @(posedge clk); #1 enable = 1'b1;
    step(10);
    wait_slot(2, 2, "t5_sync_rst");
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("t5_rst_com", 32'(com), 32'h0000000F);
    @(negedge clk);
    check("t5_first_com", 32'(com), GHOST ? 32'h0000000F : 32'h0000000E);
    step(24);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
